counter_sched: RTL
==================

// Module: counter_sched
// PURPOSE
//  Round-robin scheduler sharing one programmable counter (16-bit up/down, setup-bus type) among
//  N_REQ requesters as one-shot timers. Each accepted request loads a length L into the counter in
//  increase mode, waits for the counter's match pulse, then returns a done pulse to its owner.
//  Sits between timer clients and the counter's io_value/i_setup/o_match interface.
// PARAMETERS
//  WIDTH   16  counter / length width; must equal the attached counter's WIDTH
//  N_REQ   4   number of requesters, 2..16; OW = $clog2(N_REQ)
// PORTS
//  i_clk         in    1            single clock; all state on posedge
//  i_rst_n       in    1            reset, asynchronous assert, active-low
//  i_req         in    N_REQ        level request per requester
//  i_len         in    N_REQ*WIDTH  timer length; requester k at [k*WIDTH +: WIDTH]; stable while i_req[k]=1
//  i_cancel      in    N_REQ        abort own active timer
//  o_ack         out   N_REQ        1-cycle pulse: request accepted, length captured
//  o_done        out   N_REQ        1-cycle pulse: timer expired
//  o_busy        out   1            timer in LOAD/WAIT/ZLEN
//  o_owner       out   OW           index of current or last owner
//  o_count       out   WIDTH        counter value while WAIT, else 0
//  io_cnt_value  inout WIDTH        to counter io_value; driven with captured L only when o_cnt_setup!=00, else Z
//  o_cnt_setup   out   2            to counter i_setup; 2'b10 in LOAD, else 2'b00
//  i_cnt_match   in    1            from counter o_match
// BEHAVIOUR
//  Reset: state IDLE, o_ack=0, o_done=0, o_busy=0, o_owner=0, rr pointer=0, o_cnt_setup=00, bus Z.
//  FSM: IDLE, ZLEN, LOAD, WAIT. All outputs registered except io_cnt_value/o_cnt_setup/o_count,
//   which decode from the registered state only; no input-to-output combinational path.
//  IDLE: if any i_req, grant the first requester at or after rr pointer, wrapping.
//   Capture len, set o_owner, pulse o_ack[k], and set rr pointer=(k+1) mod N_REQ.
//   Next state is ZLEN if len==0, else LOAD.
//  ZLEN: the counter never matches for L=0, so the counter is not touched. Next edge: o_done[k]=1, go IDLE.
//  LOAD: one cycle with o_cnt_setup=10 and L on the bus. The counter loads at the closing edge,
//   which also clears its o_match. Go WAIT.
//  WAIT: o_cnt_setup=00, o_count=io_cnt_value. On the edge sampling i_cnt_match=1: o_done[k]=1, go IDLE.
//   i_cnt_match is ignored in every other state; the counter free-runs between jobs.
//  Latency: accept at edge A -> o_ack high after A; o_done high after edge A+L+2, for L>=1.
//   Earliest next accept is edge A+L+3. For L=0, o_done is high after A+1.
//  Cancel: i_cancel[o_owner] in LOAD/WAIT/ZLEN -> IDLE next edge, no o_done.
//   Cancel on the same edge as a match also gives no o_done. A cancel in LOAD still loads the counter (harmless).
//   i_cancel from a non-owner, or in IDLE, is ignored.
//  A requester still asserting i_req after its o_ack/o_done is treated as a new request.
//   Clients drop i_req the cycle o_ack is seen.
//  Bus: the controller drives io_cnt_value iff o_cnt_setup!=00. The counter drives it iff its i_setup==00.
//   Exactly one driver at any time, X-free after reset.
//  Reset mid-operation: immediate return to reset values, bus released, no o_done issued.
//   The counter shares i_rst_n.
//  Width: o_count is truncated to WIDTH bits. Any L up to {WIDTH{1'b1}} is legal.
// TESTING
//  T1 single: req[0], L=5 at edge 0 -> o_ack[0] after e0, setup=10 cycle 1, o_done[0] after e7, o_busy 0 after e7.
//  T2 round-robin: req=4'b1111, all L=1 -> ack order 0,1,2,3,0; every done 3 edges after its ack.
//  T3 L=0: req[2], L=0 -> o_ack[2] then o_done[2] next cycle; o_cnt_setup stays 00; counter untouched.
//  T4 cancel: req[1], L=10; i_cancel[1] 4 cycles after ack -> IDLE, no o_done; i_cancel[3] meanwhile ignored.
//  T5 boundary: L=16'hFFFF -> o_done exactly 65537 edges after the ack edge; cancel coincident with match -> no done.
//  T6 reset: deassert i_rst_n during WAIT -> all outputs 0 and bus Z same cycle; after release, req[3] L=2 -> done after A+4.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched
//   Round-robin scheduler that time-shares one external 16-bit up/down counter
//   (setup-bus style) among N_REQ requesters, each using it as a one-shot timer.
//   An accepted request loads its length L into the counter, waits for the
//   counter's match pulse, then returns a done pulse to the requester.
//
// Ports
//   i_clk         clock, all state on posedge
//   i_rst_n       asynchronous active-low reset
//   i_req         level request per requester
//   i_len         timer length per requester, requester k at [k*WIDTH +: WIDTH]
//   i_cancel      abort own active timer
//   o_ack         1-cycle pulse: request accepted, length captured
//   o_done        1-cycle pulse: timer expired
//   o_busy        a timer is in progress (ZLEN/LOAD/WAIT)
//   o_owner       index of current or last owner
//   o_count       counter value while waiting, else 0
//   io_cnt_value  counter value bus; driven with L only while loading
//   o_cnt_setup   counter setup code; 2'b10 while loading, else 2'b00
//   i_cnt_match   counter match pulse
module counter_sched #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4,
  localparam int OW = $clog2(N_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_len,
  input  logic [N_REQ-1:0]       i_cancel,
  output logic [N_REQ-1:0]       o_ack,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy,
  output logic [OW-1:0]          o_owner,
  output logic [WIDTH-1:0]       o_count,
  inout  logic [WIDTH-1:0]       io_cnt_value,
  output logic [1:0]             o_cnt_setup,
  input  logic                   i_cnt_match
);

  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {
    IDLE,
    ZLEN,
    LOAD,
    WAIT
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   len_q;
  logic [OW-1:0]      owner_q;
  logic [OW-1:0]      rr_q;
  logic [N_REQ-1:0]   ack_q;
  logic [N_REQ-1:0]   done_q;

  logic               gnt_vld;
  logic [OW-1:0]      gnt_idx;
  logic [OW-1:0]      cand;
  logic [WIDTH-1:0]   gnt_len;
  logic [N_REQ-1:0]   gnt_oh;
  logic [N_REQ-1:0]   owner_oh;
  logic [OW-1:0]      rr_next;
  logic               cancel_own;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      cand = OW'((32'(rr_q) + i) % NR);
      if (!gnt_vld && i_req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_len  = '0;
    gnt_oh   = '0;
    owner_oh = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (gnt_idx == OW'(i)) begin
        gnt_len   = i_len[i*WIDTH +: WIDTH];
        gnt_oh[i] = gnt_vld;
      end
      if (owner_q == OW'(i)) begin
        owner_oh[i] = 1'b1;
      end
    end
  end

  assign rr_next    = OW'((32'(gnt_idx) + 1) % NR);
  assign cancel_own = i_cancel[owner_q];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      ack_q   <= '0;
      done_q  <= '0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            len_q   <= gnt_len;
            owner_q <= gnt_idx;
            ack_q   <= gnt_oh;
            rr_q    <= rr_next;
            state_q <= (gnt_len == '0) ? ZLEN : LOAD;
          end
        end
        // The counter never matches a zero length, so expire without touching it.
        ZLEN: begin
          if (!cancel_own) done_q <= owner_oh;
          state_q <= IDLE;
        end
        LOAD: begin
          state_q <= cancel_own ? IDLE : WAIT;
        end
        WAIT: begin
          if (cancel_own) begin
            state_q <= IDLE;
          end else if (i_cnt_match) begin
            done_q  <= owner_oh;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ack   = ack_q;
  assign o_done  = done_q;
  assign o_owner = owner_q;
  assign o_busy  = (state_q != IDLE);

  // Bus ownership follows the setup code: we drive only while loading,
  // the counter drives whenever its setup input is 2'b00.
  assign o_cnt_setup  = (state_q == LOAD) ? 2'b10 : 2'b00;
  assign io_cnt_value = (state_q == LOAD) ? len_q : 'z;
  assign o_count      = (state_q == WAIT) ? io_cnt_value : '0;

endmodule
